// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore control FSM for a multicycle MIPS datapath with a shared
//   instruction/data memory. Sequences fetch, decode, execute, memory and
//   writeback over several cycles, stalls on a memory-ready handshake,
//   supports an immediate-ALU class and flags unsupported instructions.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   op, funct  opcode / funct fields from the instruction register
//   zero       ALU zero flag (used only for branch resolution)
//   mem_ready  memory access completes this cycle
//   iord       memory address select (0 = PC, 1 = ALUOut)
//   mem_write  memory write enable
//   ir_write   instruction register load
//   pc_en      PC load enable
//   pc_src     00 = ALU result, 01 = ALUOut, 10 = jump target
//   alu_src_a  0 = PC, 1 = register A
//   alu_src_b  00 = B, 01 = 4, 10 = ext imm, 11 = sign-ext imm << 2
//   alu_ctl    000 and, 001 or, 010 add, 110 sub, 111 slt (zero-extended)
//   ext_op     1 = sign-extend, 0 = zero-extend immediate
//   reg_dst    1 = rd, 0 = rt
//   mem_to_reg 1 = memory data, 0 = ALUOut
//   reg_write  register file write enable
//   illegal_op one-cycle pulse on an unsupported instruction
//   state      current state encoding (debug)
module multicycle_controller #(
    parameter int ALUCTL_W      = 3,
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                iord,
    output logic                mem_write,
    output logic                ir_write,
    output logic                pc_en,
    output logic [1:0]          pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUCTL_W-1:0] alu_ctl,
    output logic                ext_op,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                illegal_op,
    output logic [3:0]          state
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_IEXEC  = 4'd9;
    localparam logic [3:0] S_IWB    = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] state_reg, state_next;
    logic       bne_q_reg, bne_q_next;
    logic       ready;

    // R-type and immediate decode; the IR holds op/funct for the whole
    // instruction, so EXEC/IEXEC can decode them directly.
    logic       funct_ok, imm_ok, imm_zext;
    logic [2:0] funct_ctl, imm_ctl, ctl3;

    // Raw enables before the reset gate.
    logic ir_write_raw, pc_write, branch, mem_write_raw, reg_write_raw;

    assign ready = mem_ready | ~USE_MEM_READY;

    always_comb begin
        funct_ok  = 1'b1;
        funct_ctl = ALU_ADD;
        case (funct)
            6'b100000: funct_ctl = ALU_ADD;
            6'b100010: funct_ctl = ALU_SUB;
            6'b100100: funct_ctl = ALU_AND;
            6'b100101: funct_ctl = ALU_OR;
            6'b101010: funct_ctl = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        imm_ok   = 1'b1;
        imm_ctl  = ALU_ADD;
        imm_zext = 1'b0;
        case (op)
            OP_ADDI: imm_ctl = ALU_ADD;
            OP_ANDI: begin imm_ctl = ALU_AND; imm_zext = 1'b1; end
            OP_ORI:  begin imm_ctl = ALU_OR;  imm_zext = 1'b1; end
            OP_SLTI: imm_ctl = ALU_SLT;
            default: imm_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
            bne_q_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            bne_q_reg <= bne_q_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        bne_q_next = bne_q_reg;
        illegal_op = 1'b0;
        case (state_reg)
            S_FETCH: if (ready) state_next = S_DECODE;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW) begin
                    state_next = S_MEMADR;
                end else if (op == OP_RTYPE && funct_ok) begin
                    state_next = S_EXEC;
                end else if (op == OP_BEQ || op == OP_BNE) begin
                    state_next = S_BRANCH;
                    bne_q_next = op[0];
                end else if (imm_ok) begin
                    state_next = S_IEXEC;
                end else if (op == OP_J) begin
                    state_next = S_JUMP;
                end else begin
                    state_next = S_FETCH;
                    illegal_op = 1'b1;
                end
            end
            S_MEMADR: state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (ready) state_next = S_MEMWB;
            S_MEMWR:  if (ready) state_next = S_FETCH;
            S_EXEC:   state_next = S_ALUWB;
            S_IEXEC:  state_next = S_IWB;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        iord          = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        pc_src        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        ctl3          = ALU_ADD;
        ext_op        = 1'b1;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write_raw = 1'b0;
        case (state_reg)
            S_FETCH: begin
                alu_src_b    = 2'b01;
                ir_write_raw = ready;
                pc_write     = ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg    = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_MEMWR: begin
                iord          = 1'b1;
                mem_write_raw = ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                ctl3      = funct_ctl;
            end
            S_ALUWB: begin
                reg_dst       = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                ctl3      = ALU_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ctl3      = imm_ctl;
                ext_op    = ~imm_zext;
            end
            S_IWB: reg_write_raw = 1'b1;
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_ctl = ALUCTL_W'(ctl3);

    // Write enables are held off combinationally while reset is asserted so
    // an abandoned instruction can never commit a partial result.
    assign ir_write  = ir_write_raw  & rst_n;
    assign mem_write = mem_write_raw & rst_n;
    assign reg_write = reg_write_raw & rst_n;
    assign pc_en     = (pc_write | (branch & (bne_q_reg ^ zero))) & rst_n;
    assign state     = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: table-driven instruction vectors
// plus hand-written stall, mid-instruction reset and no-handshake sequences.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, funct;
    logic       zero, mem_ready;

    logic       iord, mem_write, ir_write, pc_en, alu_src_a, ext_op;
    logic       reg_dst, mem_to_reg, reg_write, illegal_op;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_ctl;
    logic [3:0] state;

    logic       iord2, mem_write2, ir_write2, pc_en2, alu_src_a2, ext_op2;
    logic       reg_dst2, mem_to_reg2, reg_write2, illegal_op2;
    logic [1:0] pc_src2, alu_src_b2;
    logic [2:0] alu_ctl2;
    logic [3:0] state2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.ALUCTL_W(3), .USE_MEM_READY(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .mem_write(mem_write),
        .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctl(alu_ctl),
        .ext_op(ext_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .illegal_op(illegal_op), .state(state)
    );

    // Handshake disabled, memory never reports ready.
    multicycle_controller #(.ALUCTL_W(3), .USE_MEM_READY(1'b0)) dut_nr (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(1'b0), .iord(iord2), .mem_write(mem_write2),
        .ir_write(ir_write2), .pc_en(pc_en2), .pc_src(pc_src2),
        .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .alu_ctl(alu_ctl2),
        .ext_op(ext_op2), .reg_dst(reg_dst2), .mem_to_reg(mem_to_reg2),
        .reg_write(reg_write2), .illegal_op(illegal_op2), .state(state2)
    );

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [7:0]  rdy;     // bit i = mem_ready in cycle i
        int          len;     // cycles until back in FETCH
        logic [31:0] seq;     // nibble i = expected state in cycle i
        logic [3:0]  chk_st;  // state in which outputs below are checked
        logic [2:0]  alu;
        logic [1:0]  pcs;
        logic        pce;
        logic        ext;
        int          n_ill;
        int          n_rw;
        int          n_mw;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] o, input logic [5:0] f,
                                input logic z, input logic [7:0] r, input int l,
                                input logic [31:0] s, input logic [3:0] cs,
                                input logic [2:0] a, input logic [1:0] ps,
                                input logic pe, input logic e, input int ni,
                                input int nr, input int nm);
        vec_t v;
        v.op = o; v.funct = f; v.zero = z; v.rdy = r; v.len = l; v.seq = s;
        v.chk_st = cs; v.alu = a; v.pcs = ps; v.pce = pe; v.ext = e;
        v.n_ill = ni; v.n_rw = nr; v.n_mw = nm;
        return v;
    endfunction

    // Entered between a negedge and the next posedge with the DUT in FETCH.
    task automatic run_vec(input vec_t v, input string tag);
        int ill = 0, rw = 0, mw = 0, ir = 0;
        logic [3:0] es;
        op = v.op; funct = v.funct; zero = v.zero;
        for (int i = 0; i < v.len; i++) begin
            mem_ready = v.rdy[i];
            es = v.seq[4*i +: 4];
            #1;
            chk($sformatf("%s state c%0d", tag, i), 32'(state), 32'(es));
            chk($sformatf("%s mem_to_reg c%0d", tag, i), 32'(mem_to_reg), 32'(es == 4'd4));
            if (es == v.chk_st) begin
                chk($sformatf("%s alu_ctl", tag), 32'(alu_ctl), 32'(v.alu));
                chk($sformatf("%s pc_src", tag), 32'(pc_src), 32'(v.pcs));
                chk($sformatf("%s pc_en", tag), 32'(pc_en), 32'(v.pce));
                chk($sformatf("%s ext_op", tag), 32'(ext_op), 32'(v.ext));
            end
            ill += int'(illegal_op);
            rw  += int'(reg_write);
            mw  += int'(mem_write);
            ir  += int'(ir_write);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        chk($sformatf("%s end state", tag), 32'(state), 32'd0);
        chk($sformatf("%s illegal pulses", tag), 32'(ill), 32'(v.n_ill));
        chk($sformatf("%s reg_write cycles", tag), 32'(rw), 32'(v.n_rw));
        chk($sformatf("%s mem_write cycles", tag), 32'(mw), 32'(v.n_mw));
        chk($sformatf("%s ir_write cycles", tag), 32'(ir), 32'd1);
        $display("vec %s op=%b funct=%b zero=%b len=%0d done", tag, v.op, v.funct, v.zero, v.len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //              op         funct      z  rdy    len seq        cs    alu     pcs  pe ext ill rw mw
        vecs[0]  = mk(6'b100011, 6'b000000, 0, 8'hFF, 5, 32'h43210, 4'd2,  3'b010, 2'b00, 0, 1, 0, 1, 0); // lw
        vecs[1]  = mk(6'b101011, 6'b000000, 0, 8'hFF, 4, 32'h5210,  4'd2,  3'b010, 2'b00, 0, 1, 0, 0, 1); // sw
        vecs[2]  = mk(6'b000000, 6'b100000, 0, 8'hFF, 4, 32'h7610,  4'd6,  3'b010, 2'b00, 0, 1, 0, 1, 0); // add
        vecs[3]  = mk(6'b000000, 6'b100010, 0, 8'hFF, 4, 32'h7610,  4'd6,  3'b110, 2'b00, 0, 1, 0, 1, 0); // sub
        vecs[4]  = mk(6'b000000, 6'b100100, 0, 8'hFF, 4, 32'h7610,  4'd6,  3'b000, 2'b00, 0, 1, 0, 1, 0); // and
        vecs[5]  = mk(6'b000000, 6'b100101, 0, 8'hFF, 4, 32'h7610,  4'd6,  3'b001, 2'b00, 0, 1, 0, 1, 0); // or
        vecs[6]  = mk(6'b000000, 6'b101010, 0, 8'hFF, 4, 32'h7610,  4'd6,  3'b111, 2'b00, 0, 1, 0, 1, 0); // slt
        vecs[7]  = mk(6'b000100, 6'b000000, 1, 8'hFF, 3, 32'h810,   4'd8,  3'b110, 2'b01, 1, 1, 0, 0, 0); // beq taken
        vecs[8]  = mk(6'b000100, 6'b000000, 0, 8'hFF, 3, 32'h810,   4'd8,  3'b110, 2'b01, 0, 1, 0, 0, 0); // beq not taken
        vecs[9]  = mk(6'b000101, 6'b000000, 0, 8'hFF, 3, 32'h810,   4'd8,  3'b110, 2'b01, 1, 1, 0, 0, 0); // bne taken
        vecs[10] = mk(6'b000101, 6'b000000, 1, 8'hFF, 3, 32'h810,   4'd8,  3'b110, 2'b01, 0, 1, 0, 0, 0); // bne not taken
        vecs[11] = mk(6'b001000, 6'b000000, 0, 8'hFF, 4, 32'hA910,  4'd9,  3'b010, 2'b00, 0, 1, 0, 1, 0); // addi
        vecs[12] = mk(6'b001100, 6'b000000, 0, 8'hFF, 4, 32'hA910,  4'd9,  3'b000, 2'b00, 0, 0, 0, 1, 0); // andi
        vecs[13] = mk(6'b001101, 6'b000000, 0, 8'hFF, 4, 32'hA910,  4'd9,  3'b001, 2'b00, 0, 0, 0, 1, 0); // ori
        vecs[14] = mk(6'b001010, 6'b000000, 0, 8'hFF, 4, 32'hA910,  4'd9,  3'b111, 2'b00, 0, 1, 0, 1, 0); // slti
        vecs[15] = mk(6'b000010, 6'b000000, 0, 8'hFF, 3, 32'hB10,   4'd11, 3'b010, 2'b10, 1, 1, 0, 0, 0); // j
        vecs[16] = mk(6'b111111, 6'b000000, 0, 8'hFF, 2, 32'h10,    4'd1,  3'b010, 2'b00, 0, 1, 1, 0, 0); // illegal op
        vecs[17] = mk(6'b000000, 6'b000000, 0, 8'hFF, 2, 32'h10,    4'd1,  3'b010, 2'b00, 0, 1, 1, 0, 0); // illegal funct

        // Reset held for two cycles: no write enables.
        rst_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk($sformatf("reset ir_write c%0d", i), 32'(ir_write), 32'd0);
            chk($sformatf("reset pc_en c%0d", i), 32'(pc_en), 32'd0);
            chk($sformatf("reset reg_write c%0d", i), 32'(reg_write), 32'd0);
            chk($sformatf("reset mem_write c%0d", i), 32'(mem_write), 32'd0);
        end
        chk("reset state", 32'(state), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("first fetch ir_write", 32'(ir_write), 32'd1);
        chk("first fetch pc_en", 32'(pc_en), 32'd1);
        chk("first fetch alu_src_b", 32'(alu_src_b), 32'd1);
        chk("first fetch alu_ctl", 32'(alu_ctl), 32'b010);
        $display("reset sequence checked");

        for (int k = 0; k < 18; k++) run_vec(vecs[k], $sformatf("v%0d", k));

        // Stall corner cases.
        run_vec(mk(6'b100011, 6'b000000, 0, 8'b11100111, 7, 32'h4333210, 4'd3,
                   3'b010, 2'b00, 0, 1, 0, 1, 0), "lw_memrd_stall");
        run_vec(mk(6'b101011, 6'b000000, 0, 8'b11100111, 6, 32'h555210, 4'd5,
                   3'b010, 2'b00, 0, 1, 0, 0, 1), "sw_memwr_stall");
        run_vec(mk(6'b001000, 6'b000000, 0, 8'b11111110, 5, 32'hA9100, 4'd9,
                   3'b010, 2'b00, 0, 1, 0, 1, 0), "addi_fetch_stall");

        // Reset in MEMWR abandons the store.
        op = 6'b101011; funct = 6'd0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("midreset state before", 32'(state), 32'd5);
        chk("midreset mem_write before", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset mem_write gated", 32'(mem_write), 32'd0);
        @(negedge clk); #1;
        chk("midreset state after", 32'(state), 32'd0);
        chk("midreset nr state after", 32'(state2), 32'd0);
        $display("mid-instruction reset checked");

        // Handshake disabled: lw runs at full speed with mem_ready stuck low.
        rst_n = 1'b1; op = 6'b100011;
        #1;
        chk("nr ir_write", 32'(ir_write2), 32'd1);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] exp_seq;
            exp_seq = 32'h043210;
            chk($sformatf("nr lw state c%0d", i), 32'(state2), 32'(exp_seq[4*i +: 4]));
            @(negedge clk); #1;
        end
        $display("no-handshake lw checked");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
